// File: rtl/dual_port_ram_ctl.sv
`default_nettype none
// ============================================================================
// Module   : dual_port_ram_ctl
// Brief    : Simple-dual-port RAM with a write port (A) and a registered
//            read port (B). It has byte-lane write enables, a selectable
//            read-during-write mode with collision flagging, and a clear
//            sequencer that zeroes the array after every reset.
// Options  : RAM_OUT_REG_EN - adds one output register stage, so read
//            latency becomes 2 edges.
// Revision : 1.0 - initial release
// ============================================================================
module dual_port_ram_ctl #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int RDW_MODE = 0
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  ce,
   input  logic                  we,
   input  logic [DATA_W/8-1:0]   be,
   input  logic [ADDR_W-1:0]     adr_a,
   input  logic [DATA_W-1:0]     din,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     adr_b,
   output logic [DATA_W-1:0]     dout,
   output logic                  dout_vld,
   output logic                  collision,
   output logic                  init_busy
);

   localparam int LANES = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   clr_ptr;
   logic                clr_last;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                wr_en;
   logic                rd_en;
   logic                hit;
   logic [DATA_W-1:0]   old_a;
   logic [DATA_W-1:0]   merged;
   logic [DATA_W-1:0]   rd_word;

   // First read stage registers
   logic [DATA_W-1:0]   dout_s1;
   logic                vld_s1;
   logic                col_s1;

   assign clr_last  = (clr_ptr == ADDR_W'(DEPTH - 1));
   assign init_busy = (state == CLEAR);

   // Requests only count once the array has been cleared.
   assign wr_en = (state == READY) & ce & we;
   assign rd_en = (state == READY) & ce & re;
   assign hit   = wr_en & rd_en & (adr_a == adr_b);

   // Word at the write address with enabled lanes replaced by din.
   assign old_a = mem[adr_a];

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign merged[8*i +: 8] = be[i] ? din[8*i +: 8] : old_a[8*i +: 8];
   end

   // Same-address read returns either the pre-write or the merged word.
   if (RDW_MODE == 1) begin : g_rdw_new
      assign rd_word = hit ? merged : mem[adr_b];
   end else begin : g_rdw_old
      assign rd_word = mem[adr_b];
   end

   // Clear sequencer state and pointer; reset restarts the clear at 0.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state   <= CLEAR;
         clr_ptr <= '0;
      end else begin
         state <= state_nxt;
         if (state == CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
         end
      end
   end

   // Leave CLEAR on the edge that zeroes the last address.
   always_comb begin
      state_nxt = state;
      if ((state == CLEAR) && clr_last) begin
         state_nxt = READY;
      end
   end

   // Array update: zeroing while clearing, otherwise the lane-merged write.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[clr_ptr] <= '0;
      end else if (wr_en) begin
         mem[adr_a] <= merged;
      end
   end

   // Read register: dout holds between reads, flags pulse per read.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         dout_s1 <= '0;
         vld_s1  <= 1'b0;
         col_s1  <= 1'b0;
      end else begin
         vld_s1 <= rd_en;
         col_s1 <= hit;
         if (rd_en) begin
            dout_s1 <= rd_word;
         end
      end
   end

`ifdef RAM_OUT_REG_EN
   logic [DATA_W-1:0]   dout_s2;
   logic                vld_s2;
   logic                col_s2;

   // Extra output stage: delays data and flags together, holds data when idle.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         dout_s2 <= '0;
         vld_s2  <= 1'b0;
         col_s2  <= 1'b0;
      end else begin
         vld_s2 <= vld_s1;
         col_s2 <= col_s1;
         if (vld_s1) begin
            dout_s2 <= dout_s1;
         end
      end
   end

   assign dout      = dout_s2;
   assign dout_vld  = vld_s2;
   assign collision = col_s2;
`else
   assign dout      = dout_s1;
   assign dout_vld  = vld_s1;
   assign collision = col_s1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dual_port_ram_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_port_ram_ctl
// Brief    : Directed self-checking bench for dual_port_ram_ctl. Two
//            instances share all inputs: one with RDW_MODE 0, one with
//            RDW_MODE 1. Honors RAM_OUT_REG_EN for read latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_port_ram_ctl;

`ifdef RAM_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk;
   logic        nrst;
   logic        ce;
   logic        we;
   logic [1:0]  be;
   logic [3:0]  adr_a;
   logic [15:0] din;
   logic        re;
   logic [3:0]  adr_b;
   logic [15:0] dout0, dout1;
   logic        vld0, vld1;
   logic        col0, col1;
   logic        busy0, busy1;

   int tests;
   int fails;

   dual_port_ram_ctl #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(0)) u_old (
      .clk(clk), .nrst(nrst), .ce(ce), .we(we), .be(be), .adr_a(adr_a),
      .din(din), .re(re), .adr_b(adr_b), .dout(dout0), .dout_vld(vld0),
      .collision(col0), .init_busy(busy0)
   );

   dual_port_ram_ctl #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(1)) u_new (
      .clk(clk), .nrst(nrst), .ce(ce), .we(we), .be(be), .adr_a(adr_a),
      .din(din), .re(re), .adr_b(adr_b), .dout(dout1), .dout_vld(vld1),
      .collision(col1), .init_busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_in(input logic c, input logic w, input logic r,
                         input logic [1:0] b, input logic [3:0] aa,
                         input logic [3:0] ab, input logic [15:0] d);
      ce = c; we = w; re = r; be = b; adr_a = aa; adr_b = ab; din = d;
   endtask

   // Apply one request for one edge, then idle until its result is visible.
   task automatic step(input logic c, input logic w, input logic r,
                       input logic [1:0] b, input logic [3:0] aa,
                       input logic [3:0] ab, input logic [15:0] d);
      set_in(c, w, r, b, aa, ab, d);
      @(posedge clk); #1;
      set_in(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 16'h0000);
      for (int k = 1; k < LAT; k++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      int n;
      logic bad_vld;
      nrst = 1'b0;
      set_in(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 16'h0000);
      #2;
      tests++;
      if (dout0 !== 16'h0000 || vld0 !== 1'b0 || col0 !== 1'b0 || busy0 !== 1'b1) begin
         fails++;
         $display("FAIL reset_values: dout=%h vld=%b col=%b busy=%b, want 0000 0 0 1",
                  dout0, vld0, col0, busy0);
      end
      @(posedge clk); @(posedge clk); #1;
      nrst = 1'b1;
      // Requests during the clear must be ignored.
      set_in(1'b1, 1'b1, 1'b1, 2'b11, 4'h2, 4'h2, 16'hFFFF);
      n = 0;
      bad_vld = 1'b0;
      while (busy0 === 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (vld0 !== 1'b0 || col0 !== 1'b0) bad_vld = 1'b1;
      end
      set_in(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 16'h0000);
      tests++;
      if (n !== 16) begin
         fails++;
         $display("FAIL clear_duration: busy edges=%0d, want 16", n);
      end
      tests++;
      if (bad_vld !== 1'b0) begin
         fails++;
         $display("FAIL busy_gating: dout_vld/collision seen=%b, want 0", bad_vld);
      end
      for (int a = 0; a < 16; a++) begin
         step(1'b1, 1'b0, 1'b1, 2'b00, 4'h0, 4'(a), 16'h0000);
         tests++;
         if (dout0 !== 16'h0000 || vld0 !== 1'b1 || dout1 !== 16'h0000) begin
            fails++;
            $display("FAIL clear_read_%0d: dout=%h/%h vld=%b, want 0000 1", a, dout0, dout1, vld0);
         end
      end
   endtask

   task automatic test_write_read;
      step(1'b1, 1'b1, 1'b0, 2'b11, 4'h3, 4'h0, 16'hA5C3);
      tests++;
      if (vld0 !== 1'b0) begin
         fails++;
         $display("FAIL write_no_vld: dout_vld=%b, want 0", vld0);
      end
      step(1'b1, 1'b0, 1'b1, 2'b00, 4'h0, 4'h3, 16'h0000);
      tests++;
      if (dout0 !== 16'hA5C3 || vld0 !== 1'b1 || col0 !== 1'b0) begin
         fails++;
         $display("FAIL write_read: dout=%h vld=%b col=%b, want a5c3 1 0", dout0, vld0, col0);
      end
      @(posedge clk); #1;
      tests++;
      if (dout0 !== 16'hA5C3 || vld0 !== 1'b0) begin
         fails++;
         $display("FAIL dout_hold: dout=%h vld=%b, want a5c3 0", dout0, vld0);
      end
   endtask

   task automatic test_byte_enable;
      step(1'b1, 1'b1, 1'b0, 2'b11, 4'h5, 4'h0, 16'h1234);
      step(1'b1, 1'b1, 1'b0, 2'b10, 4'h5, 4'h0, 16'hFF00);
      step(1'b1, 1'b0, 1'b1, 2'b00, 4'h0, 4'h5, 16'h0000);
      tests++;
      if (dout0 !== 16'hFF34 || vld0 !== 1'b1) begin
         fails++;
         $display("FAIL be_high_lane: dout=%h vld=%b, want ff34 1", dout0, vld0);
      end
      step(1'b1, 1'b1, 1'b0, 2'b00, 4'h5, 4'h0, 16'h9999);
      step(1'b1, 1'b0, 1'b1, 2'b00, 4'h0, 4'h5, 16'h0000);
      tests++;
      if (dout0 !== 16'hFF34) begin
         fails++;
         $display("FAIL be_none: dout=%h, want ff34", dout0);
      end
      step(1'b1, 1'b1, 1'b0, 2'b01, 4'h5, 4'h0, 16'h00AB);
      step(1'b1, 1'b0, 1'b1, 2'b00, 4'h0, 4'h5, 16'h0000);
      tests++;
      if (dout0 !== 16'hFFAB) begin
         fails++;
         $display("FAIL be_low_lane: dout=%h, want ffab", dout0);
      end
   endtask

   task automatic test_collision;
      step(1'b1, 1'b1, 1'b0, 2'b11, 4'h7, 4'h0, 16'h1111);
      step(1'b1, 1'b1, 1'b1, 2'b11, 4'h7, 4'h7, 16'h2222);
      tests++;
      if (dout0 !== 16'h1111 || col0 !== 1'b1 || vld0 !== 1'b1) begin
         fails++;
         $display("FAIL collision_old: dout=%h col=%b vld=%b, want 1111 1 1", dout0, col0, vld0);
      end
      tests++;
      if (dout1 !== 16'h2222 || col1 !== 1'b1) begin
         fails++;
         $display("FAIL collision_new: dout=%h col=%b, want 2222 1", dout1, col1);
      end
      step(1'b1, 1'b0, 1'b1, 2'b00, 4'h0, 4'h7, 16'h0000);
      tests++;
      if (dout0 !== 16'h2222 || col0 !== 1'b0 || dout1 !== 16'h2222 || col1 !== 1'b0) begin
         fails++;
         $display("FAIL after_collision: dout=%h/%h col=%b/%b, want 2222 0", dout0, dout1, col0, col1);
      end
      // Partial-lane collision: mode 1 must merge lanes.
      step(1'b1, 1'b1, 1'b1, 2'b01, 4'h7, 4'h7, 16'h33CC);
      tests++;
      if (dout0 !== 16'h2222 || dout1 !== 16'h22CC || col1 !== 1'b1) begin
         fails++;
         $display("FAIL collision_merge: dout=%h/%h col=%b, want 2222/22cc 1", dout0, dout1, col1);
      end
      // Different addresses read and written together: no collision.
      step(1'b1, 1'b1, 1'b1, 2'b11, 4'h9, 4'h3, 16'h7777);
      tests++;
      if (dout0 !== 16'hA5C3 || col0 !== 1'b0 || vld0 !== 1'b1) begin
         fails++;
         $display("FAIL no_collision: dout=%h col=%b vld=%b, want a5c3 0 1", dout0, col0, vld0);
      end
   endtask

   task automatic test_chip_enable;
      step(1'b1, 1'b1, 1'b0, 2'b11, 4'h2, 4'h0, 16'h4444);
      step(1'b1, 1'b0, 1'b1, 2'b00, 4'h0, 4'h2, 16'h0000);
      step(1'b0, 1'b1, 1'b1, 2'b11, 4'h2, 4'h2, 16'hBEEF);
      tests++;
      if (dout0 !== 16'h4444 || vld0 !== 1'b0 || col0 !== 1'b0) begin
         fails++;
         $display("FAIL ce_off: dout=%h vld=%b col=%b, want 4444 0 0", dout0, vld0, col0);
      end
      step(1'b1, 1'b0, 1'b1, 2'b00, 4'h0, 4'h2, 16'h0000);
      tests++;
      if (dout0 !== 16'h4444) begin
         fails++;
         $display("FAIL ce_off_mem: dout=%h, want 4444", dout0);
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] exp_d [3];
      logic [3:0]  adr   [3];
      exp_d[0] = 16'hA5C3; exp_d[1] = 16'hFFAB; exp_d[2] = 16'h22CC;
      adr[0]   = 4'h3;     adr[1]   = 4'h5;     adr[2]   = 4'h7;
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 1'b0, 1'b1, 2'b00, 4'h0, adr[i], 16'h0000);
         @(posedge clk); #1;
         if (i >= LAT - 1) begin
            tests++;
            if (dout0 !== exp_d[i - (LAT - 1)] || vld0 !== 1'b1) begin
               fails++;
               $display("FAIL b2b_%0d: dout=%h vld=%b, want %h 1", i, dout0, vld0, exp_d[i - (LAT - 1)]);
            end
         end
      end
      set_in(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 16'h0000);
      for (int k = 1; k < LAT; k++) begin
         @(posedge clk); #1;
      end
      tests++;
      if (dout0 !== 16'h22CC || vld0 !== 1'b1) begin
         fails++;
         $display("FAIL b2b_last: dout=%h vld=%b, want 22cc 1", dout0, vld0);
      end
   endtask

   task automatic test_reset_mid_clear;
      int n;
      step(1'b1, 1'b1, 1'b0, 2'b11, 4'hC, 4'h0, 16'h5A5A);
      step(1'b1, 1'b0, 1'b1, 2'b00, 4'h0, 4'hC, 16'h0000);
      tests++;
      if (dout0 !== 16'h5A5A || vld0 !== 1'b1) begin
         fails++;
         $display("FAIL pre_reset_read: dout=%h vld=%b, want 5a5a 1", dout0, vld0);
      end
      #2;
      nrst = 1'b0;
      #1;
      tests++;
      if (dout0 !== 16'h0000 || vld0 !== 1'b0 || busy0 !== 1'b1) begin
         fails++;
         $display("FAIL async_reset: dout=%h vld=%b busy=%b, want 0000 0 1", dout0, vld0, busy0);
      end
      @(posedge clk); #1;
      nrst = 1'b1;
      repeat (8) begin
         @(posedge clk); #1;
      end
      tests++;
      if (busy0 !== 1'b1) begin
         fails++;
         $display("FAIL mid_clear_busy: busy=%b, want 1", busy0);
      end
      nrst = 1'b0;
      #1;
      @(posedge clk); #1;
      nrst = 1'b1;
      n = 0;
      while (busy0 === 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      tests++;
      if (n !== 16) begin
         fails++;
         $display("FAIL reclear_duration: busy edges=%0d, want 16", n);
      end
      step(1'b1, 1'b0, 1'b1, 2'b00, 4'h0, 4'hC, 16'h0000);
      tests++;
      if (dout0 !== 16'h0000 || vld0 !== 1'b1) begin
         fails++;
         $display("FAIL reclear_read: dout=%h vld=%b, want 0000 1", dout0, vld0);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_write_read();
      test_byte_enable();
      test_collision();
      test_chip_enable();
      test_back_to_back();
      test_reset_mid_clear();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
